// File: rtl/rf_wport_arbiter_pkg.sv
// rf_wport_arbiter_pkg: shared widths, FSM encodings and LU FIFO entry layout for the rf write-port arbiter.
package rf_wport_arbiter_pkg;
    localparam int WS_TO_RF_BUS_WD = 38;

    typedef enum logic {
        WBARB_PIPE_PRI = 1'b0,
        WBARB_LU_FORCE = 1'b1
    } wbarb_state_e;

    typedef struct packed {
        logic [4:0]  dest;
        logic [31:0] wdata;
        logic [31:0] pc;
    } lu_entry_t;
endpackage

// File: rtl/rf_wport_arbiter_fifo.sv
// wbarb_fifo: LU result queue with per-entry valid bits driving a registered GR busy mask.
module wbarb_fifo
    import rf_wport_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  lu_entry_t   din,
    output lu_entry_t   head,
    output logic        full,
    output logic        empty,
    output logic [31:0] busy_mask
);
    localparam int AW = $clog2(DEPTH);

    lu_entry_t        mem [DEPTH];
    logic [DEPTH-1:0] vld, vld_n;
    logic [AW:0]      wptr, rptr;
    logic [31:0]      mask_n;

    assign empty = wptr == rptr;
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign head  = mem[rptr[AW-1:0]];

    // Mask is built from the post-edge contents so it changes on the same edge as push/pop.
    always_comb begin
        vld_n = vld;
        if (pop) vld_n[rptr[AW-1:0]] = 1'b0;
        if (push) vld_n[wptr[AW-1:0]] = 1'b1;
        mask_n = '0;
        for (int i = 0; i < DEPTH; i++)
            if (vld_n[i]) mask_n[(push && wptr[AW-1:0] == AW'(i)) ? din.dest : mem[i].dest] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr      <= '0;
            rptr      <= '0;
            vld       <= '0;
            busy_mask <= '0;
        end else begin
            wptr      <= wptr + (AW+1)'(push);
            rptr      <= rptr + (AW+1)'(pop);
            vld       <= vld_n;
            busy_mask <= mask_n;
        end
    end

    always_ff @(posedge clk)
        if (push) mem[wptr[AW-1:0]] <= din;
endmodule

// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter: shares the regfile write port between WB (priority) and a buffered long-latency unit.
// Define WBARB_FWD_EN to expose the FIFO head on fwd_* for forwarding.
module rf_wport_arbiter
    import rf_wport_arbiter_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pipe_valid,
    input  logic                       pipe_we,
    input  logic [4:0]                 pipe_dest,
    input  logic [31:0]                pipe_wdata,
    input  logic [31:0]                pipe_pc,
    output logic                       pipe_ready,
    input  logic                       lu_valid,
    input  logic [4:0]                 lu_dest,
    input  logic [31:0]                lu_wdata,
    input  logic [31:0]                lu_pc,
    output logic                       lu_ready,
    output logic [31:0]                lu_busy_mask,
    output logic                       fwd_valid,
    output logic [4:0]                 fwd_dest,
    output logic [31:0]                fwd_data,
    output logic [WS_TO_RF_BUS_WD-1:0] ws_to_rf_bus,
    output logic [31:0]                debug_wb_pc,
    output logic [3:0]                 debug_wb_rf_we,
    output logic [4:0]                 debug_wb_rf_wnum,
    output logic [31:0]                debug_wb_rf_wdata
);
    localparam int CW = $clog2(STARVE_MAX) + 1;

    wbarb_state_e state, state_n;
    logic [CW-1:0] starve_cnt, starve_n;
    logic          pipe_grant, pop, push, full, empty;
    lu_entry_t     head;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [31:0]   rf_wdata;

    wbarb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .din       ({lu_dest, lu_wdata, lu_pc}),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .busy_mask (lu_busy_mask)
    );

    assign lu_ready = !full;
    // A full FIFO still takes a new entry when its head leaves on the same edge.
    assign push = lu_valid && (!full || pop);

    always_comb begin
        pipe_ready = state == WBARB_PIPE_PRI;
        pipe_grant = pipe_valid && pipe_ready;
        pop        = !empty && !pipe_grant;
        starve_n   = (empty || pop) ? '0 : starve_cnt + 1'b1;
        state_n    = (state == WBARB_PIPE_PRI && !empty && !pop && starve_cnt == CW'(STARVE_MAX - 1))
                     ? WBARB_LU_FORCE : WBARB_PIPE_PRI;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= WBARB_PIPE_PRI;
            starve_cnt  <= '0;
            rf_we       <= 1'b0;
            rf_waddr    <= '0;
            rf_wdata    <= '0;
            debug_wb_pc <= '0;
        end else begin
            state      <= state_n;
            starve_cnt <= starve_n;
            rf_we      <= pipe_grant ? (pipe_we && pipe_dest != 5'd0) : (pop && head.dest != 5'd0);
            if (pipe_grant) begin
                rf_waddr    <= pipe_dest;
                rf_wdata    <= pipe_wdata;
                debug_wb_pc <= pipe_pc;
            end else if (pop) begin
                rf_waddr    <= head.dest;
                rf_wdata    <= head.wdata;
                debug_wb_pc <= head.pc;
            end
        end
    end

    assign ws_to_rf_bus      = {rf_we, rf_waddr, rf_wdata};
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

`ifdef WBARB_FWD_EN
    assign fwd_valid = !empty;
    assign fwd_dest  = head.dest;
    assign fwd_data  = head.wdata;
`else
    assign fwd_valid = 1'b0;
    assign fwd_dest  = '0;
    assign fwd_data  = '0;
`endif
endmodule

// File: tb/tb_rf_wport_arbiter.sv
// tb_rf_wport_arbiter: directed self-checking bench for the rf write-port arbiter (DEPTH=2, STARVE_MAX=4).
module tb_rf_wport_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_valid, pipe_we, pipe_ready;
    logic [4:0]  pipe_dest;
    logic [31:0] pipe_wdata, pipe_pc;
    logic        lu_valid, lu_ready;
    logic [4:0]  lu_dest;
    logic [31:0] lu_wdata, lu_pc, lu_busy_mask;
    logic        fwd_valid;
    logic [4:0]  fwd_dest;
    logic [31:0] fwd_data;
    logic [37:0] ws_to_rf_bus;
    logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rf_wport_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .pipe_valid(pipe_valid), .pipe_we(pipe_we), .pipe_dest(pipe_dest),
        .pipe_wdata(pipe_wdata), .pipe_pc(pipe_pc), .pipe_ready(pipe_ready),
        .lu_valid(lu_valid), .lu_dest(lu_dest), .lu_wdata(lu_wdata), .lu_pc(lu_pc),
        .lu_ready(lu_ready), .lu_busy_mask(lu_busy_mask),
        .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
        .ws_to_rf_bus(ws_to_rf_bus), .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        pipe_valid = 0; pipe_we = 0; pipe_dest = 0; pipe_wdata = 0; pipe_pc = 0;
        lu_valid = 0; lu_dest = 0; lu_wdata = 0; lu_pc = 0;
    endtask

    task automatic test_reset;
        idle;
        reset = 1;
        step; step;
        reset = 0;
        checks++; if (ws_to_rf_bus !== 38'h0) begin errors++; $display("FAIL reset_bus: got %h expected 0", ws_to_rf_bus); end
        checks++; if (debug_wb_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", debug_wb_pc); end
        checks++; if (debug_wb_rf_we !== 4'h0) begin errors++; $display("FAIL reset_dbg_we: got %h expected 0", debug_wb_rf_we); end
        checks++; if (lu_busy_mask !== 32'h0) begin errors++; $display("FAIL reset_mask: got %h expected 0", lu_busy_mask); end
        checks++; if ({fwd_valid, fwd_dest, fwd_data} !== 38'h0) begin errors++; $display("FAIL reset_fwd: got %b/%h/%h expected 0", fwd_valid, fwd_dest, fwd_data); end
        checks++; if (pipe_ready !== 1'b1) begin errors++; $display("FAIL reset_pipe_ready: got %b expected 1", pipe_ready); end
        checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL reset_lu_ready: got %b expected 1", lu_ready); end
    endtask

    task automatic test_pipe_only;
        idle;
        pipe_valid = 1; pipe_we = 1; pipe_dest = 5'd3; pipe_wdata = 32'h11; pipe_pc = 32'h100;
        checks++; if (pipe_ready !== 1'b1) begin errors++; $display("FAIL pipe_ready: got %b expected 1", pipe_ready); end
        step;
        idle;
        checks++; if (ws_to_rf_bus !== {1'b1, 5'd3, 32'h11}) begin errors++; $display("FAIL pipe_bus: got %h expected %h", ws_to_rf_bus, {1'b1, 5'd3, 32'h11}); end
        checks++; if (debug_wb_pc !== 32'h100) begin errors++; $display("FAIL pipe_pc: got %h expected 100", debug_wb_pc); end
        checks++; if (debug_wb_rf_we !== 4'hf || debug_wb_rf_wnum !== 5'd3 || debug_wb_rf_wdata !== 32'h11) begin errors++; $display("FAIL pipe_trace: got %h/%h/%h expected f/03/11", debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata); end
        step;
        checks++; if (ws_to_rf_bus !== {1'b0, 5'd3, 32'h11}) begin errors++; $display("FAIL pipe_idle_hold: got %h expected %h", ws_to_rf_bus, {1'b0, 5'd3, 32'h11}); end
    endtask

    task automatic test_lu_idle;
        logic        exp_fv;
        logic [4:0]  exp_fd;
        logic [31:0] exp_fdata;
`ifdef WBARB_FWD_EN
        exp_fv = 1'b1; exp_fd = 5'd5; exp_fdata = 32'hAB;
`else
        exp_fv = 1'b0; exp_fd = 5'd0; exp_fdata = 32'h0;
`endif
        idle;
        lu_valid = 1; lu_dest = 5'd5; lu_wdata = 32'hAB; lu_pc = 32'h200;
        checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL lu_ready: got %b expected 1", lu_ready); end
        checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL lu_fwd_empty: got %b expected 0", fwd_valid); end
        step;
        idle;
        checks++; if (ws_to_rf_bus[37] !== 1'b0) begin errors++; $display("FAIL lu_no_bypass: got %b expected 0", ws_to_rf_bus[37]); end
        checks++; if (lu_busy_mask !== 32'h20) begin errors++; $display("FAIL lu_mask_set: got %h expected 20", lu_busy_mask); end
        checks++; if (fwd_valid !== exp_fv || fwd_dest !== exp_fd || fwd_data !== exp_fdata) begin errors++; $display("FAIL lu_fwd: got %b/%h/%h expected %b/%h/%h", fwd_valid, fwd_dest, fwd_data, exp_fv, exp_fd, exp_fdata); end
        step;
        checks++; if (ws_to_rf_bus !== {1'b1, 5'd5, 32'hAB}) begin errors++; $display("FAIL lu_write: got %h expected %h", ws_to_rf_bus, {1'b1, 5'd5, 32'hAB}); end
        checks++; if (debug_wb_pc !== 32'h200) begin errors++; $display("FAIL lu_pc: got %h expected 200", debug_wb_pc); end
        checks++; if (lu_busy_mask !== 32'h0) begin errors++; $display("FAIL lu_mask_clear: got %h expected 0", lu_busy_mask); end
        checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL lu_fwd_drained: got %b expected 0", fwd_valid); end
        step;
        checks++; if (ws_to_rf_bus[37] !== 1'b0) begin errors++; $display("FAIL lu_one_cycle: got %b expected 0", ws_to_rf_bus[37]); end
    endtask

    task automatic test_starvation;
        int          idx = 0;
        logic [4:0]  exp_a;
        logic [31:0] exp_d;
        idle;
        for (int c = 0; c < 7; c++) begin
            pipe_valid = 1; pipe_we = 1; pipe_dest = 5'd1;
            pipe_wdata = 32'h1000 + 32'(idx); pipe_pc = 32'h300 + 32'(idx);
            lu_valid = (c == 0); lu_dest = 5'd7; lu_wdata = 32'h77; lu_pc = 32'h400;
            checks++; if (pipe_ready !== (c != 5)) begin errors++; $display("FAIL starve_ready c%0d: got %b expected %b", c, pipe_ready, c != 5); end
            if (c >= 1 && c <= 5) begin
                checks++; if (lu_busy_mask !== 32'h80) begin errors++; $display("FAIL starve_mask c%0d: got %h expected 80", c, lu_busy_mask); end
            end
            step;
            exp_a = (c == 5) ? 5'd7 : 5'd1;
            exp_d = (c == 5) ? 32'h77 : 32'h1000 + 32'(idx);
            if (c != 5) idx++;
            checks++; if (ws_to_rf_bus !== {1'b1, exp_a, exp_d}) begin errors++; $display("FAIL starve_bus c%0d: got %h expected %h", c, ws_to_rf_bus, {1'b1, exp_a, exp_d}); end
        end
        checks++; if (lu_busy_mask !== 32'h0) begin errors++; $display("FAIL starve_mask_end: got %h expected 0", lu_busy_mask); end
        idle;
        step;
    endtask

    task automatic test_full;
        idle;
        pipe_valid = 1; pipe_we = 1; pipe_dest = 5'd2; pipe_wdata = 32'h2000;
        lu_valid = 1; lu_dest = 5'd8; lu_wdata = 32'hA0; lu_pc = 32'h500;
        step;
        pipe_wdata = 32'h2001;
        lu_dest = 5'd9; lu_wdata = 32'hB0; lu_pc = 32'h504;
        checks++; if (lu_busy_mask !== 32'h100) begin errors++; $display("FAIL full_mask1: got %h expected 100", lu_busy_mask); end
        step;
        pipe_valid = 0;
        lu_dest = 5'd10; lu_wdata = 32'hC0; lu_pc = 32'h508;
        checks++; if (lu_ready !== 1'b0) begin errors++; $display("FAIL full_lu_ready: got %b expected 0", lu_ready); end
        checks++; if (lu_busy_mask !== 32'h300) begin errors++; $display("FAIL full_mask2: got %h expected 300", lu_busy_mask); end
        checks++; if (ws_to_rf_bus !== {1'b1, 5'd2, 32'h2001}) begin errors++; $display("FAIL full_pipe_bus: got %h expected %h", ws_to_rf_bus, {1'b1, 5'd2, 32'h2001}); end
        step;
        idle;
        checks++; if (ws_to_rf_bus !== {1'b1, 5'd8, 32'hA0}) begin errors++; $display("FAIL full_order_a: got %h expected %h", ws_to_rf_bus, {1'b1, 5'd8, 32'hA0}); end
        checks++; if (lu_ready !== 1'b0) begin errors++; $display("FAIL full_still_full: got %b expected 0", lu_ready); end
        checks++; if (lu_busy_mask !== 32'h600) begin errors++; $display("FAIL full_mask3: got %h expected 600", lu_busy_mask); end
        step;
        checks++; if (ws_to_rf_bus !== {1'b1, 5'd9, 32'hB0}) begin errors++; $display("FAIL full_order_b: got %h expected %h", ws_to_rf_bus, {1'b1, 5'd9, 32'hB0}); end
        checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL full_ready_back: got %b expected 1", lu_ready); end
        step;
        checks++; if (ws_to_rf_bus !== {1'b1, 5'd10, 32'hC0}) begin errors++; $display("FAIL full_order_c: got %h expected %h", ws_to_rf_bus, {1'b1, 5'd10, 32'hC0}); end
        checks++; if (debug_wb_pc !== 32'h508) begin errors++; $display("FAIL full_pc_c: got %h expected 508", debug_wb_pc); end
        checks++; if (lu_busy_mask !== 32'h0) begin errors++; $display("FAIL full_mask_end: got %h expected 0", lu_busy_mask); end
        step;
    endtask

    task automatic test_r0;
        idle;
        pipe_valid = 1; pipe_we = 1; pipe_dest = 5'd0; pipe_wdata = 32'hDEAD; pipe_pc = 32'h600;
        step;
        checks++; if (ws_to_rf_bus[37] !== 1'b0) begin errors++; $display("FAIL r0_we: got %b expected 0", ws_to_rf_bus[37]); end
        checks++; if (debug_wb_rf_we !== 4'h0) begin errors++; $display("FAIL r0_dbg_we: got %h expected 0", debug_wb_rf_we); end
        pipe_we = 0; pipe_dest = 5'd4;
        step;
        idle;
        checks++; if (ws_to_rf_bus[37] !== 1'b0) begin errors++; $display("FAIL nowe_we: got %b expected 0", ws_to_rf_bus[37]); end
    endtask

    task automatic test_reset_flush;
        idle;
        pipe_valid = 1; pipe_we = 1; pipe_dest = 5'd2; pipe_wdata = 32'h3000;
        lu_valid = 1; lu_dest = 5'd12; lu_wdata = 32'hE0;
        step;
        lu_dest = 5'd13; lu_wdata = 32'hF0;
        step;
        idle;
        checks++; if (lu_busy_mask !== 32'h3000) begin errors++; $display("FAIL flush_pre_mask: got %h expected 3000", lu_busy_mask); end
        reset = 1;
        step;
        reset = 0;
        checks++; if (lu_busy_mask !== 32'h0) begin errors++; $display("FAIL flush_mask: got %h expected 0", lu_busy_mask); end
        checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL flush_lu_ready: got %b expected 1", lu_ready); end
        checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL flush_fwd: got %b expected 0", fwd_valid); end
        for (int c = 0; c < 4; c++) begin
            checks++; if (ws_to_rf_bus[37] !== 1'b0) begin errors++; $display("FAIL flush_no_write c%0d: got %h", c, ws_to_rf_bus); end
            step;
        end
        test_lu_idle;
    endtask

    initial begin
        test_reset;
        test_pipe_only;
        test_lu_idle;
        test_starvation;
        test_full;
        test_r0;
        test_reset_flush;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
